// File: rtl/stage_fetch.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// debug load port, next-PC selection, IF/ID pipeline register and halt detection.
module stage_fetch #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_pc_write,
    input  logic              i_write_IF_ID,
    input  logic              i_jump,
    input  logic [31:0]       i_jump_address,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_branch_target,
    input  logic              i_mem_wenable,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_data,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc_current,
    output logic              o_halt
);

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0] pc_reg,    pc_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_ir_reg, if_ir_next;
    logic        halt_reg,  halt_next;

    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        jump_accept;
    logic        redirect;
    logic        fetch_active;
    logic        halt_set;

    // The load port is deliberately outside the reset/enable/halt domain so a
    // program can be loaded while the core is frozen or held in reset.
    always_ff @(posedge clk) begin
        if (i_mem_wenable) begin
            mem[i_mem_addr] <= i_mem_data;
        end
    end

    assign instr        = mem[pc_reg[ADDR_W+1:2]];
    assign pc_plus4     = pc_reg + 32'd4;
    assign jump_accept  = i_jump && i_pc_write;
    assign redirect     = i_branch_taken || jump_accept;
    assign fetch_active = i_enable && !halt_reg;
    assign halt_set     = fetch_active && (instr == HALT_WORD) && i_pc_write && !redirect;

    always_comb begin
        pc_next    = pc_reg;
        if_pc_next = if_pc_reg;
        if_ir_next = if_ir_reg;
        halt_next  = halt_reg | halt_set;

        // A branch comes from an older instruction, so it wins even over a stall.
        if (fetch_active) begin
            if (i_branch_taken) begin
                pc_next = i_branch_target;
            end else if (jump_accept) begin
                pc_next = {i_jump_address[29:0], 2'b00};
            end else if (i_pc_write && !halt_set) begin
                pc_next = pc_plus4;
            end
        end

        if (i_enable) begin
            if (redirect) begin
                if_ir_next = NOP_WORD;
                if_pc_next = 32'd0;
            end else if (halt_reg) begin
                if_ir_next = NOP_WORD;
            end else if (i_write_IF_ID) begin
                if_ir_next = instr;
                if_pc_next = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            pc_reg    <= 32'd0;
            if_pc_reg <= 32'd0;
            if_ir_reg <= NOP_WORD;
            halt_reg  <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            if_pc_reg <= if_pc_next;
            if_ir_reg <= if_ir_next;
            halt_reg  <= halt_next;
        end
    end

    assign o_pc          = if_pc_reg;
    assign o_instruction = if_ir_reg;
    assign o_pc_current  = pc_reg;
    assign o_halt        = halt_reg;

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory with a debug load port.
- Selects the next PC from sequential, jump, or branch sources, and obeys hazard-unit stall controls.
- Latches PC+4 and the fetched instruction for decode, and detects a program-halt word.

Parameters:
- MEM_DEPTH, 256, number of 32-bit instruction words.
- ADDR_W, 8, word-index width; MEM_DEPTH = 2**ADDR_W.
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.
- NOP_WORD, 32'h00000000, bubble inserted into IF/ID.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global run/step enable; 0 freezes PC, IF/ID and halt flag.
- i_pc_write  in  1  from hazard unit; 0 holds PC (load-use stall).
- i_write_IF_ID  in  1  from hazard unit; 0 holds IF/ID contents.
- i_jump  in  1  jump resolved in decode.
- i_jump_address  in  32  jump target as word index (decode zero-extends instr[7:0]).
- i_branch_taken  in  1  branch resolved downstream, taken.
- i_branch_target  in  32  branch target, byte address.
- i_mem_wenable  in  1  program-load write strobe.
- i_mem_addr  in  ADDR_W  program-load word index.
- i_mem_data  in  32  program-load word.
- o_pc  out  32  IF/ID: PC+4 of latched instruction.
- o_instruction  out  32  IF/ID: latched instruction.
- o_pc_current  out  32  live PC (debug).
- o_halt  out  1  sticky; HALT_WORD has been fetched.

Behaviour:
- Reset: PC=0, o_pc=0, o_instruction=NOP_WORD, o_halt=0. Memory contents are not reset. Reset overrides every other input.
- Fetch:
  - Memory read is combinational: instr = mem[PC[ADDR_W+1:2]]. PC[1:0] is ignored; PC bits above ADDR_W+1 are ignored, so the address wraps modulo MEM_DEPTH words.
  - pc_plus4 = PC + 4, 32-bit, wraps at 2**32.
- Next-PC priority, evaluated only when i_enable=1 and o_halt=0:
  1. i_branch_taken: PC <= i_branch_target. Applies even when i_pc_write=0 (the older instruction wins).
  2. i_jump && i_pc_write: PC <= {i_jump_address[29:0],2'b00}.
  3. i_pc_write: PC <= pc_plus4.
  4. Otherwise PC holds.
- IF/ID register, evaluated only when i_enable=1:
  - Redirect (branch taken, or jump accepted per rule 2): o_instruction <= NOP_WORD and o_pc <= 0, regardless of i_write_IF_ID (flush).
  - Else if o_halt=1: o_instruction <= NOP_WORD, o_pc holds.
  - Else if i_write_IF_ID: o_instruction <= instr, o_pc <= pc_plus4.
  - Else hold.
- Halt:
  - Set condition: o_halt <= 1 when i_enable && !o_halt && instr==HALT_WORD && i_pc_write && no redirect that cycle.
  - Same edge: IF/ID captures the halt word and PC holds at the halt address (does not advance).
  - A halt word on a squashed path never sets o_halt.
  - Only reset clears o_halt.
- i_enable=0: PC, IF/ID and o_halt all hold. Memory writes still occur.
- Load port: when i_mem_wenable=1, mem[i_mem_addr] <= i_mem_data on the edge. This is independent of i_enable, o_halt and i_reset. A fetch from the same word in the same cycle returns the old contents.
- Latency: an instruction at PC appears on o_instruction one cycle after PC holds that value.

Test Plan:
- Sequential fetch: load words 0..3 = 0x11,0x22,0x33,0x44, reset, run 4 cycles -> o_instruction 0x11,0x22,0x33,0x44 with o_pc 4,8,12,16.
- Load-use stall: assert i_pc_write=0 and i_write_IF_ID=0 for 1 cycle at PC=8 -> o_pc_current stays 8; o_instruction repeats 0x22; 0x33 follows the next cycle.
- Jump vs stall: i_jump=1, i_jump_address=5 with i_pc_write=1 -> PC=20 and IF/ID=NOP. Repeat with i_pc_write=0 -> jump ignored, PC holds.
- Branch over stall and jump: i_branch_taken=1, target 0x40, together with i_jump=1 and i_pc_write=0 -> PC=0x40, IF/ID flushed to NOP/0.
- Halt: word 2 = 0xFFFFFFFF -> o_halt rises after the fetch edge, o_instruction=0xFFFFFFFF for one cycle then NOP, PC frozen at 8. A halt word fetched while i_branch_taken=1 -> o_halt stays 0.
- Reset mid-run and enable: reset during a stall -> PC=0, outputs zero/NOP next edge, memory intact. i_enable=0 for 3 cycles -> no state change.
